// File: rtl/calc_pkg.sv
// Shared display constants for the calculator output path: digit count,
// fixed glyphs (internal polarity 1 = lit, bit order {g,f,e,d,c,b,a}) and the shadow record.
package calc_pkg;

   localparam int NDIG = 4;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_R     = 7'b1010000;

   typedef struct packed {
      logic [15:0] top;
      logic [6:0]  size;
      logic        empty;
      logic        error;
      logic        hi;
      logic        show_size;
   } shadow_t;

   // Power-up shadow reads as an empty stack, so the display shows dashes until the first snapshot.
   localparam shadow_t SHADOW_RESET = '{top: 16'h0000, size: 7'h00, empty: 1'b1,
                                        error: 1'b0, hi: 1'b0, show_size: 1'b0};

endpackage

// File: rtl/calc_display_hex_to_seg.sv
// Combinational nibble to 7-segment glyph decoder ({g,f,e,d,c,b,a}, 1 = lit).
module hex_to_seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b0000000;
      case (nibble)
         4'h0: seg = 7'b0111111;
         4'h1: seg = 7'b0000110;
         4'h2: seg = 7'b1011011;
         4'h3: seg = 7'b1001111;
         4'h4: seg = 7'b1100110;
         4'h5: seg = 7'b1101101;
         4'h6: seg = 7'b1111101;
         4'h7: seg = 7'b0000111;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1101111;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b1111100;
         4'hC: seg = 7'b0111001;
         4'hD: seg = 7'b1011110;
         4'hE: seg = 7'b1111001;
         4'hF: seg = 7'b1110001;
         default: seg = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/calc_display.sv
// 4-digit multiplexed 7-segment driver with frame snapshot and ghost-guard blanking.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits in top-of-stack mode.
module calc_display
   import calc_pkg::*;
#(
   parameter int DIV_BITS       = 16,
   parameter int GUARD          = 4,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] top,
   input  logic        hi_half,
   input  logic [6:0]  stack_size,
   input  logic        empty,
   input  logic        error,
   input  logic        show_size,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic                INV     = (SEG_ACTIVE_LOW != 0);
   localparam logic [6:0]          SEG_OFF = {7{INV}};
   localparam logic [DIV_BITS-1:0] GUARD_V = DIV_BITS'(GUARD);

   logic [DIV_BITS-1:0] pre_q, pre_d;
   logic [1:0]          dig_q, dig_d;
   shadow_t             sh_q, sh_d;
   logic [3:0]          an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;

   logic       tick;
   logic [3:0] nibble;
   logic [6:0] hex_seg;
   logic [6:0] seg_int;
   logic       dp_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         dig_q <= 2'd0;
         sh_q  <= SHADOW_RESET;
         an_q  <= 4'b1111;
         seg_q <= SEG_OFF;
         dp_q  <= INV;
      end else begin
         pre_q <= pre_d;
         dig_q <= dig_d;
         sh_q  <= sh_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   // Inputs are sampled only as the last digit's dwell ends, so a frame never mixes two values.
   always_comb begin
      tick  = &pre_q;
      pre_d = pre_q + 1'b1;
      dig_d = tick ? dig_q + 2'd1 : dig_q;
      sh_d  = sh_q;
      if (tick && (dig_q == 2'd3)) begin
         sh_d.top       = top;
         sh_d.size      = stack_size;
         sh_d.empty     = empty;
         sh_d.error     = error;
         sh_d.hi        = hi_half;
         sh_d.show_size = show_size;
      end
   end

   always_comb begin
      nibble = 4'h0;
      if (sh_q.show_size) begin
         nibble = (dig_q == 2'd1) ? {1'b0, sh_q.size[6:4]} : sh_q.size[3:0];
      end else begin
         case (dig_q)
            2'd3:    nibble = sh_q.top[15:12];
            2'd2:    nibble = sh_q.top[11:8];
            2'd1:    nibble = sh_q.top[7:4];
            default: nibble = sh_q.top[3:0];
         endcase
      end
   end

   hex_to_seg u_hex (
      .nibble (nibble),
      .seg    (hex_seg)
   );

`ifdef LEAD_ZERO_BLANK_EN
   logic lead_zero;
   always_comb begin
      lead_zero = 1'b0;
      case (dig_q)
         2'd3:    lead_zero = (sh_q.top[15:12] == 4'h0);
         2'd2:    lead_zero = (sh_q.top[15:8] == 8'h00);
         2'd1:    lead_zero = (sh_q.top[15:4] == 12'h000);
         default: lead_zero = 1'b0;
      endcase
   end
`endif

   always_comb begin
      seg_int = SEG_BLANK;
      dp_int  = 1'b0;
      if (sh_q.error) begin
         case (dig_q)
            2'd3:       seg_int = SEG_E;
            2'd2, 2'd1: seg_int = SEG_R;
            default:    seg_int = SEG_BLANK;
         endcase
      end else if (sh_q.empty) begin
         seg_int = SEG_DASH;
      end else if (sh_q.show_size) begin
         seg_int = (dig_q[1] == 1'b0) ? hex_seg : SEG_BLANK;
         dp_int  = (dig_q == 2'd3);
      end else begin
`ifdef LEAD_ZERO_BLANK_EN
         seg_int = lead_zero ? SEG_BLANK : hex_seg;
`else
         seg_int = hex_seg;
`endif
         dp_int  = sh_q.hi && (dig_q == 2'd0);
      end
   end

   always_comb begin
      an_d  = (pre_q < GUARD_V) ? 4'b1111 : ~(4'b0001 << dig_q);
      seg_d = seg_int ^ SEG_OFF;
      dp_d  = dp_int ^ INV;
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with DIV_BITS=4: walks whole frames and checks
// guard blanking, anode order, glyphs, decimal point, snapshot timing and async reset.
module tb_calc_display;

   logic        clk;
   logic        rst_n;
   logic [15:0] top;
   logic        hi_half;
   logic [6:0]  stack_size;
   logic        empty;
   logic        error;
   logic        show_size;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   // Internal-polarity glyphs, {g,f,e,d,c,b,a}
   localparam logic [6:0] G_BL = 7'h00;
   localparam logic [6:0] G_DA = 7'h40;
   localparam logic [6:0] G_0  = 7'h3F;
   localparam logic [6:0] G_1  = 7'h06;
   localparam logic [6:0] G_2  = 7'h5B;
   localparam logic [6:0] G_3  = 7'h4F;
   localparam logic [6:0] G_5  = 7'h6D;
   localparam logic [6:0] G_A  = 7'h77;
   localparam logic [6:0] G_B  = 7'h7C;
   localparam logic [6:0] G_C  = 7'h39;
   localparam logic [6:0] G_E  = 7'h79;
   localparam logic [6:0] G_F  = 7'h71;
   localparam logic [6:0] G_R  = 7'h50;

   calc_display #(
      .DIV_BITS       (4),
      .GUARD          (4),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .top        (top),
      .hi_half    (hi_half),
      .stack_size (stack_size),
      .empty      (empty),
      .error      (error),
      .show_size  (show_size),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at the negedge where the frame's digit 0, pre 0 is on the pins; returns 64 clocks later.
   task automatic check_frame(input string tag, input logic [27:0] glyphs, input logic [3:0] dp_lit);
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      for (int d = 0; d < 4; d++) begin
         for (int p = 0; p < 16; p++) begin
            if (p == 3) check_eq($sformatf("%s_d%0d_guard_an", tag, d), 32'(an), 32'hF);
            if (p == 4) begin
               exp_an  = ~(4'b0001 << d);
               exp_seg = ~glyphs[d*7 +: 7];
               exp_dp  = ~dp_lit[d];
               check_eq($sformatf("%s_d%0d_an", tag, d), 32'(an), 32'(exp_an));
               check_eq($sformatf("%s_d%0d_seg", tag, d), 32'(seg), 32'(exp_seg));
               check_eq($sformatf("%s_d%0d_dp", tag, d), 32'(dp), 32'(exp_dp));
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      top        = 16'h0000;
      hi_half    = 1'b0;
      stack_size = 7'h00;
      empty      = 1'b1;
      error      = 1'b0;
      show_size  = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_an", 32'(an), 32'hF);
      check_eq("reset_seg", 32'(seg), 32'h7F);
      check_eq("reset_dp", 32'(dp), 32'h1);

      rst_n = 1'b1;
      @(negedge clk);
      // New inputs arrive during frame 0; they must not appear until frame 1.
      top     = 16'h1A3F;
      empty   = 1'b0;
      hi_half = 1'b1;
      check_frame("dash0", {G_DA, G_DA, G_DA, G_DA}, 4'b0000);

      fork
         check_frame("f1a3f", {G_1, G_A, G_3, G_F}, 4'b0001);
         begin
            repeat (20) @(negedge clk);
            top = 16'h0000;
         end
      join

      error = 1'b1;
      empty = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
      check_frame("zero", {G_BL, G_BL, G_BL, G_0}, 4'b0001);
`else
      check_frame("zero", {G_0, G_0, G_0, G_0}, 4'b0001);
`endif

      error      = 1'b0;
      empty      = 1'b0;
      show_size  = 1'b1;
      stack_size = 7'h2B;
      check_frame("err", {G_E, G_R, G_R, G_BL}, 4'b0000);

      show_size = 1'b0;
      top       = 16'h00C5;
      hi_half   = 1'b0;
      check_frame("size", {G_BL, G_BL, G_2, G_B}, 4'b1000);

      top = 16'h0F00;
`ifdef LEAD_ZERO_BLANK_EN
      check_frame("c5", {G_BL, G_BL, G_C, G_5}, 4'b0000);
      check_frame("f00", {G_BL, G_F, G_0, G_0}, 4'b0000);
`else
      check_frame("c5", {G_0, G_0, G_C, G_5}, 4'b0000);
      check_frame("f00", {G_0, G_F, G_0, G_0}, 4'b0000);
`endif

      // Mid-dwell of digit 0 in the next frame, then an asynchronous reset.
      repeat (8) @(negedge clk);
      check_eq("pre_rst_an", 32'(an), 32'hE);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_an", 32'(an), 32'hF);
      check_eq("mid_rst_seg", 32'(seg), 32'h7F);
      check_eq("mid_rst_dp", 32'(dp), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_frame("rst_dash", {G_DA, G_DA, G_DA, G_DA}, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
